// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin arbiter sharing one single-port RAM between two requesters, with bounded lock
module ram_arbiter2 #(
    parameter int AW       = 14,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_a_i,
    input  logic          we_a_i,
    input  logic          lock_a_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [DW-1:0] wdata_a_i,
    output logic          gnt_a_o,
    output logic          rvalid_a_o,
    output logic [DW-1:0] rdata_a_o,
    input  logic          req_b_i,
    input  logic          we_b_i,
    input  logic          lock_b_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] wdata_b_i,
    output logic          gnt_b_o,
    output logic          rvalid_b_o,
    output logic [DW-1:0] rdata_b_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_in_o,
    output logic          mem_load_o,
    input  logic [DW-1:0] mem_out_i
);
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;
    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);
    owner_e        owner_q, owner_d;
    logic          last_b_q, last_b_d;
    logic [3:0]    lock_cnt_q, lock_cnt_d, cnt_inc;
    logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic          lock_ok, gnt_a, gnt_b;
    // grant selection: lock owner first, then sole requester, then round-robin; suppressed during reset
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        lock_ok = lock_cnt_q < MAX_CNT;
        if (owner_q == OWN_A && req_a_i && lock_ok) gnt_a = 1'b1;
        else if (owner_q == OWN_B && req_b_i && lock_ok) gnt_b = 1'b1;
        else if (req_a_i && req_b_i) begin
            gnt_a = last_b_q;
            gnt_b = !last_b_q;
        end else begin
            gnt_a = req_a_i;
            gnt_b = req_b_i;
        end
        gnt_a = gnt_a & rst_ni;
        gnt_b = gnt_b & rst_ni;
    end
    assign gnt_a_o    = gnt_a;
    assign gnt_b_o    = gnt_b;
    assign mem_addr_o = gnt_b ? addr_b_i : addr_a_i;
    assign mem_in_o   = gnt_b ? wdata_b_i : wdata_a_i;
    assign mem_load_o = (gnt_a & we_a_i) | (gnt_b & we_b_i);
    assign cnt_inc    = lock_cnt_q + {3'b000, lock_cnt_q != 4'hF};
    // next state: ownership bookkeeping on grants, lock abandonment, registered read return
    always_comb begin
        last_b_d   = last_b_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt_a) begin
            last_b_d   = 1'b0;
            owner_d    = lock_a_i ? OWN_A : OWN_NONE;
            lock_cnt_d = !lock_a_i ? 4'd0 : owner_q == OWN_A ? cnt_inc : 4'd1;
        end else if (gnt_b) begin
            last_b_d   = 1'b1;
            owner_d    = lock_b_i ? OWN_B : OWN_NONE;
            lock_cnt_d = !lock_b_i ? 4'd0 : owner_q == OWN_B ? cnt_inc : 4'd1;
        end else if ((owner_q == OWN_A && !req_a_i) || (owner_q == OWN_B && !req_b_i)) begin
            owner_d    = OWN_NONE;
            lock_cnt_d = 4'd0;
        end
        rvalid_a_d = gnt_a & !we_a_i;
        rvalid_b_d = gnt_b & !we_b_i;
        rdata_a_d  = rvalid_a_d ? mem_out_i : rdata_a_q;
        rdata_b_d  = rvalid_b_d ? mem_out_i : rdata_b_q;
    end
    // state registers; B counts as last served out of reset so A wins the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_b_q   <= 1'b1;
            owner_q    <= OWN_NONE;
            lock_cnt_q <= 4'd0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            last_b_q   <= last_b_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end
    assign rvalid_a_o = rvalid_a_q;
    assign rvalid_b_o = rvalid_b_q;
    assign rdata_a_o  = rdata_a_q;
    assign rdata_b_o  = rdata_b_q;
endmodule

// File: tb/tb_ram_arbiter2.sv
// tb_ram_arbiter2: directed vector bench for ram_arbiter2 with a RAM16K-style memory model
module tb_ram_arbiter2;
    typedef struct packed {
        logic        r, w, l;
        logic [13:0] a;
        logic [15:0] d;
    } req_t;
    typedef struct packed {
        logic        ga, gb, ld;
        logic [13:0] ma;
        logic [15:0] mi;
        logic        rva, rvb;
        logic [15:0] rda, rdb;
    } exp_t;
    typedef struct packed {
        req_t a, b;
        exp_t e;
    } vec_t;
    localparam int N = 23;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_a, we_a, lock_a, req_b, we_b, lock_b;
    logic [13:0] addr_a, addr_b, mem_addr;
    logic [15:0] wdata_a, wdata_b, mem_in, mem_out, rdata_a, rdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, mem_load;
    logic [15:0] ram [16384];
    int          vec_n = 0, miss_n = 0;
    vec_t        vt [N];
    always #5 clk = ~clk;
    assign mem_out = ram[mem_addr];
    always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;
    ram_arbiter2 dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_a_i(req_a), .we_a_i(we_a), .lock_a_i(lock_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
        .gnt_a_o(gnt_a), .rvalid_a_o(rvalid_a), .rdata_a_o(rdata_a),
        .req_b_i(req_b), .we_b_i(we_b), .lock_b_i(lock_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
        .gnt_b_o(gnt_b), .rvalid_b_o(rvalid_b), .rdata_b_o(rdata_b),
        .mem_addr_o(mem_addr), .mem_in_o(mem_in), .mem_load_o(mem_load), .mem_out_i(mem_out)
    );
    function automatic req_t rd(input logic [13:0] a);
        return {1'b1, 1'b0, 1'b0, a, 16'h0000};
    endfunction
    function automatic req_t rdl(input logic [13:0] a);
        return {1'b1, 1'b0, 1'b1, a, 16'h0000};
    endfunction
    function automatic req_t wr(input logic [13:0] a, input logic [15:0] d);
        return {1'b1, 1'b1, 1'b0, a, d};
    endfunction
    function automatic req_t id(input logic [13:0] a, input logic [15:0] d);
        return {1'b0, 1'b0, 1'b0, a, d};
    endfunction
    task automatic drive(input req_t a, input req_t b);
        {req_a, we_a, lock_a, addr_a, wdata_a} = a;
        {req_b, we_b, lock_b, addr_b, wdata_b} = b;
    endtask
    task automatic chk(input string name, input exp_t e);
        exp_t act;
        act = {gnt_a, gnt_b, mem_load, mem_addr, mem_in, rvalid_a, rvalid_b, rdata_a, rdata_b};
        vec_n++;
        if (act !== e) begin
            miss_n++;
            $display("FAIL %s: got gnt=%b%b ld=%b addr=%h in=%h rv=%b%b rda=%h rdb=%h, want gnt=%b%b ld=%b addr=%h in=%h rv=%b%b rda=%h rdb=%h",
                     name, act.ga, act.gb, act.ld, act.ma, act.mi, act.rva, act.rvb, act.rda, act.rdb,
                     e.ga, e.gb, e.ld, e.ma, e.mi, e.rva, e.rvb, e.rda, e.rdb);
        end
    endtask
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 16'(i) ^ 16'hA000;
        vt[0]  = '{id(14'h0, 16'h0), id(14'h0, 16'h0), '{1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000}};
        vt[1]  = '{wr(14'h10, 16'h1234), id(14'h0, 16'h0), '{1'b1, 1'b0, 1'b1, 14'h0010, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000}};
        vt[2]  = '{rd(14'h10), id(14'h0, 16'h0), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000}};
        vt[3]  = '{id(14'h555, 16'h7777), id(14'h0, 16'h0), '{1'b0, 1'b0, 1'b0, 14'h0555, 16'h7777, 1'b1, 1'b0, 16'h1234, 16'h0000}};
        vt[4]  = '{rd(14'h10), rd(14'h20), '{1'b0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000}};
        vt[5]  = '{rd(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA020}};
        vt[6]  = '{rd(14'h10), rd(14'h20), '{1'b0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[7]  = '{rd(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA020}};
        vt[8]  = '{id(14'h555, 16'h7777), id(14'h0, 16'h0), '{1'b0, 1'b0, 1'b0, 14'h0555, 16'h7777, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[9]  = '{rdl(14'h10), rd(14'h20), '{1'b0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'hA020}};
        vt[10] = '{rdl(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA020}};
        vt[11] = '{rdl(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[12] = '{rdl(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[13] = '{rdl(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[14] = '{rdl(14'h10), rd(14'h20), '{1'b0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[15] = '{rdl(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA020}};
        vt[16] = '{rdl(14'h10), rd(14'h20), '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[17] = '{id(14'h0, 16'h0), id(14'h0, 16'h0), '{1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hA020}};
        vt[18] = '{rdl(14'h10), rd(14'h20), '{1'b0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'hA020}};
        vt[19] = '{id(14'h0, 16'h0), id(14'h0, 16'h0), '{1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA020}};
        vt[20] = '{id(14'h0, 16'h0), wr(14'h3FFF, 16'hBEEF), '{1'b0, 1'b1, 1'b1, 14'h3FFF, 16'hBEEF, 1'b0, 1'b0, 16'h1234, 16'hA020}};
        vt[21] = '{id(14'h0, 16'h0), rd(14'h3FFF), '{1'b0, 1'b1, 1'b0, 14'h3FFF, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'hA020}};
        vt[22] = '{id(14'h0, 16'h0), id(14'h0, 16'h0), '{1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hBEEF}};
        drive(rd(14'h10), rd(14'h20));
        @(posedge clk) #1;
        chk("in_reset", '{1'b0, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000});
        drive(id(14'h0, 16'h0), id(14'h0, 16'h0));
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            drive(vt[i].a, vt[i].b);
            #4;
            chk($sformatf("vec%0d", i), vt[i].e);
            @(posedge clk) #1;
        end
        drive(rdl(14'h10), rd(14'h20));
        #4;
        chk("pre_rst_gnt", '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'hBEEF});
        @(posedge clk) #1;
        chk("pre_rst_rv", '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hBEEF});
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", '{1'b0, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000});
        @(negedge clk);
        drive(rd(14'h10), rd(14'h20));
        rst_n = 1'b1;
        #1;
        chk("post_rst_a", '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000});
        @(posedge clk) #1;
        chk("post_rst_b", '{1'b0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000});
        @(posedge clk) #1;
        chk("post_rst_a2", '{1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hA020});
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule

// File: doc/ram_arbiter2.md
Name: ram_arbiter2

Overview:
- Two-requester round-robin arbiter that shares one single-port 16-bit RAM (RAM16K-style: combinational read, write on rising clk when load=1) between requester A (CPU data port) and requester B (DMA / screen-refresh engine).
- Performs one access per cycle.
- Returns read data registered, with a valid pulse.
- Supports a bounded lock so a requester can perform back-to-back accesses, e.g. read-modify-write.

Parameters:
- AW, 14, address width; matches RAM16K.
- DW, 16, data width.
- MAX_LOCK, 4, maximum consecutive grants to one requester while its lock is held (1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_a  in  1  A requests an access; held with addr/we/wdata stable until granted.
- we_a  in  1  1 = write, 0 = read.
- lock_a  in  1  A asks to keep ownership after the current grant.
- addr_a  in  AW  A address.
- wdata_a  in  DW  A write data.
- gnt_a  out  1  A's access is performed at this rising edge.
- rvalid_a  out  1  rdata_a valid; one-cycle pulse.
- rdata_a  out  DW  A read data.
- req_b, we_b, lock_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as the A ports, for requester B.
- mem_addr  out  AW  to RAM address.
- mem_in  out  DW  to RAM in.
- mem_load  out  1  to RAM load.
- mem_out  in  DW  from RAM out.

Behaviour:
- State registers:
  - last: last-served requester, A or B.
  - owner: none, A or B.
  - lock_cnt: 4 bits.
  - rvalid_a, rvalid_b, rdata_a, rdata_b.
- Reset (reset=0, asynchronous):
  - last=B, so A wins the first tie.
  - owner=none, lock_cnt=0.
  - rvalid_a=rvalid_b=0, rdata_a=rdata_b=0.
  - gnt_a=gnt_b=0 and mem_load=0 while reset is asserted.
- Grant selection is combinational from the registered state plus the current requests. At most one grant per cycle.
  1. If owner=X and req_X=1 and lock_cnt<MAX_LOCK: grant X.
  2. Otherwise, if only one requester is active: grant it.
  3. Otherwise, if both are active: grant the one that is not `last`.
  4. Otherwise: no grant.
- Memory mux:
  - mem_addr/mem_in follow the granted requester.
  - With no grant, mem_addr/mem_in follow A, and mem_load=0.
  - mem_load = gnt & we of the granted requester.
  - A write commits at the same edge.
- Read return: on an edge where X is granted with we_X=0:
  - rdata_X <= mem_out and rvalid_X <= 1 for the following cycle (latency 1).
  - Otherwise rvalid_X <= 0.
  - rdata_X holds its value when not updated.
- Writes produce no rvalid.
- Bookkeeping on each granted edge for X:
  - last <= X.
  - If lock_X=1:
    - If owner was already X, lock_cnt <= lock_cnt+1; otherwise lock_cnt <= 1.
    - owner <= X.
  - If lock_X=0: owner <= none, lock_cnt <= 0.
- Lock release:
  - If owner=X and req_X=0 at an edge, owner <= none and lock_cnt <= 0 (lock abandoned).
  - When lock_cnt reaches MAX_LOCK, rule 1 no longer applies, so round-robin resumes. If the other requester is active it wins next, and owner/lock_cnt clear because that grant goes to the other requester.
- Lock for one requester never starves the other for more than MAX_LOCK consecutive cycles.
- Simultaneous identical requests on consecutive cycles alternate A, B, A, B...
- Reset mid-lock or mid-read discards the pending rvalid and the lock.
- A write already committed at an edge before reset stays in memory.
- req dropped without a grant: no effect. Requesters must not drop req before the grant; behaviour in that case is the plain combinational result.

Test Plan:
- Reset, then req_a=1, we_a=1, addr_a=0x0010, wdata_a=0x1234 for one cycle -> gnt_a=1, mem_load=1, mem_addr=0x0010, mem_in=0x1234. Next cycle A reads 0x0010 -> gnt_a=1, and one cycle later rvalid_a=1, rdata_a=0x1234.
- req_a and req_b both held with reads for 4 cycles after reset -> grant order A, B, A, B; each rvalid follows its grant by exactly 1 cycle.
- MAX_LOCK=4; A holds lock_a=1 with continuous reads; B requests from cycle 0 -> A is granted 4 consecutive cycles, then B is granted in cycle 5.
- A locks (lock_cnt=2), then drops req_a; B requesting -> B is granted on the next cycle; owner=none and lock_cnt=0 afterwards.
- Assert reset low asynchronously (between edges) in the cycle after a read grant -> rvalid_a drops to 0 immediately, gnt_a=gnt_b=0 during reset. After release, with both requesting, A wins.
- B writes 0xBEEF to 0x3FFF (top address) while A is idle -> gnt_b=1, mem_load=1, mem_addr=0x3FFF; gnt_a stays 0 and rvalid_a stays 0.
